// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction-memory access arbiter.
package imem_arb_pkg;

  // BOOT holds fetch off while the loader writes the image; RUN arbitrates.
  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } imem_arb_state_t;

  // Returned in place of memory data for a faulted fetch (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Byte address to word index. The caller keeps only the low IDX_W bits.
  function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of consecutive cycles in which a pending fetch was denied.
module imem_starve_ctr #(
  parameter  int MAX   = 4,
  localparam int CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic             at_max,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  // Clear wins over increment; increment stops at MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_W'(MAX))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign at_max = (cnt_q == CNT_W'(MAX));
  assign cnt    = cnt_q;

endmodule

// File: rtl/imem_access_arbiter.sv
// Shares the single-port instruction memory between the fetch stage and the
// program loader. BOOT: loader only, fetch held off. RUN: loader has priority
// unless fetch has been denied STARVE_MAX cycles in a row.
// Optional build macro IMEM_ADDR_CHECK_EN: misaligned / out-of-range addresses
// are granted but never reach the memory; faulted fetches return a NOP and
// addr_err pulses the cycle after the faulted grant.
//
// Handshakes: a loader write transfers in any cycle with ld_valid & ld_ready
// (the loader holds ld_addr/ld_data until then); fetch_gnt means the read was
// issued this cycle and its word appears on fetch_rdata with fetch_rvalid in
// the next cycle; there is no fetch backpressure on the return path.
module imem_access_arbiter
  import imem_arb_pkg::*;
#(
  parameter  int DATA_W      = 32,
  parameter  int DEPTH_WORDS = 64,
  parameter  int STARVE_MAX  = 4,
  localparam int IDX_W       = $clog2(DEPTH_WORDS),
  localparam int CNT_W       = $clog2(STARVE_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              ld_valid,
  input  logic [31:0]       ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              ld_done,
  output logic              boot_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              addr_err,
  output imem_arb_state_t   dbg_state,
  output logic [CNT_W-1:0]  dbg_starve_cnt
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

  imem_arb_state_t state, state_nxt;
  logic            at_max;
  logic            ld_gnt;
  logic            fetch_fault, ld_fault;
  logic            rvalid_q, nop_q, err_q;
  logic [31:0]     fetch_word, ld_word;
  logic            unused_addr_bits;

  assign fetch_word = byte_to_word(fetch_addr);
  assign ld_word    = byte_to_word(ld_addr);
  // Upper index bits are dropped on purpose: addresses wrap modulo depth.
  assign unused_addr_bits = ^{fetch_word[31:IDX_W], ld_word[31:IDX_W],
                              fetch_addr[1:0], ld_addr[1:0]};

`ifdef IMEM_ADDR_CHECK_EN
  assign fetch_fault = (fetch_addr[1:0] != 2'b00) || (fetch_addr >= ADDR_LIMIT);
  assign ld_fault    = (ld_addr[1:0] != 2'b00) || (ld_addr >= ADDR_LIMIT);
`else
  assign fetch_fault = 1'b0;
  assign ld_fault    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_nxt;
  end

  // Next state and grants; everything is forced low while reset is held.
  always_comb begin
    state_nxt = state;
    fetch_gnt = 1'b0;
    ld_ready  = 1'b0;
    boot_busy = 1'b0;
    if (!reset) begin
      case (state)
        BOOT: begin
          ld_ready  = 1'b1;
          boot_busy = 1'b1;
          if (ld_done) state_nxt = RUN;
        end
        RUN: begin
          fetch_gnt = fetch_req & (~ld_valid | at_max);
          ld_ready  = ~(fetch_req & at_max);
        end
        default: state_nxt = BOOT;
      endcase
    end
  end

  assign ld_gnt = ld_valid & ld_ready;

  imem_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   ((state == RUN) & fetch_req & ~fetch_gnt),
    .clr   (~fetch_req | fetch_gnt),
    .at_max(at_max),
    .cnt   (dbg_starve_cnt)
  );

  // Memory port drive from the winning requester; faulted accesses stay off.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch_gnt) begin
      mem_en   = ~fetch_fault;
      mem_addr = fetch_word[IDX_W-1:0];
    end else if (ld_gnt && !ld_fault) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ld_word[IDX_W-1:0];
      mem_wdata = ld_data;
    end
  end

  // Read-return tracking: valid, NOP substitution and fault pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      nop_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= fetch_gnt;
      nop_q    <= fetch_gnt & fetch_fault;
      err_q    <= (fetch_gnt & fetch_fault) | (ld_gnt & ld_fault);
    end
  end

  assign fetch_rvalid = rvalid_q;
  assign fetch_rdata  = rvalid_q ? (nop_q ? DATA_W'(NOP_INSTR) : mem_rdata) : '0;
  assign addr_err     = err_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Bench for imem_access_arbiter: directed scenarios plus random traffic,
// checked every cycle against a reference model of the arbitration rules.
module tb_imem_access_arbiter;
  import imem_arb_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int SMAX   = 4;
  localparam int IDX_W  = 6;
  localparam int CNT_W  = 3;
`ifdef IMEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              fetch_req, fetch_gnt, fetch_rvalid;
  logic [31:0]       fetch_addr;
  logic [DATA_W-1:0] fetch_rdata;
  logic              ld_valid, ld_ready, ld_done, boot_busy;
  logic [31:0]       ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              mem_en, mem_we, addr_err;
  logic [IDX_W-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  imem_arb_state_t   dbg_state;
  logic [CNT_W-1:0]  dbg_starve_cnt;

  imem_access_arbiter #(.DATA_W(DATA_W), .DEPTH_WORDS(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .boot_busy(boot_busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .addr_err(addr_err),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- memory environment (1-cycle synchronous read) ----------
  function automatic logic [31:0] seed_word(input int i);
    return 32'hC0DE_0000 + 32'(i * 32'h0101);
  endfunction

  logic [DATA_W-1:0] tb_mem [DEPTH];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= seed_word(i);
      mem_ready <= 1'b1;
    end else begin
      if (mem_en && mem_we)  tb_mem[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= tb_mem[mem_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];   // words owed to the fetch stage, in order

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] img [DEPTH];  // what the memory should hold
  bit m_boot = 1'b1;
  int m_starve = 0;                // consecutive denied fetch cycles
  bit m_err = 1'b0;
  int n_fgnt = 0;                  // fetch grants seen by step()
  int n_rvalid = 0;

  function automatic bit faulted(input logic [31:0] a);
    return CHK && ((a % 4) != 0 || a >= 4 * DEPTH);
  endfunction

  // One clock: check outputs mid-cycle against the model, advance the model.
  task automatic step();
    bit fg, lg, ff, lf, busy;
    int fi, li;
    logic [DATA_W-1:0] exp_rd;
    bit exp_rv;
    @(negedge clk);
    fi = int'((fetch_addr / 4) % DEPTH);
    li = int'((ld_addr / 4) % DEPTH);
    ff = faulted(fetch_addr);
    lf = faulted(ld_addr);
    fg = 1'b0; lg = 1'b0; busy = 1'b0;
    if (!reset) begin
      if (m_boot) begin
        busy = 1'b1;
        lg   = ld_valid;
      end else begin
        fg = fetch_req && (!ld_valid || m_starve == SMAX);
        lg = ld_valid && !fg;
      end
    end
    exp_rv = (exp_q.size() != 0) && !reset;
    exp_rd = exp_rv ? exp_q[0] : '0;

    chk("fetch_gnt", 32'(fetch_gnt), 32'(fg));
    chk("boot_busy", 32'(boot_busy), 32'(busy));
    if (reset || m_boot || ld_valid) chk("ld_ready", 32'(ld_ready), 32'(reset ? 1'b0 : (m_boot | lg)));
    chk("fetch_rvalid", 32'(fetch_rvalid), 32'(exp_rv));
    chk("fetch_rdata", fetch_rdata, exp_rd);
    chk("addr_err", 32'(addr_err), 32'(m_err && !reset));
    chk("dbg_state", 32'(dbg_state), 32'((reset || m_boot) ? BOOT : RUN));
    chk("starve_cnt", 32'(dbg_starve_cnt), 32'(reset ? 0 : m_starve));
    if (fg) begin
      chk("mem_en_f", 32'(mem_en), 32'(!ff));
      if (!ff) begin
        chk("mem_we_f", 32'(mem_we), 32'h0);
        chk("mem_addr_f", 32'(mem_addr), 32'(fi));
      end
    end else if (lg) begin
      chk("mem_en_w", 32'(mem_en), 32'(!lf));
      if (!lf) begin
        chk("mem_we_w", 32'(mem_we), 32'h1);
        chk("mem_addr_w", 32'(mem_addr), 32'(li));
        chk("mem_wdata", mem_wdata, ld_data);
      end
    end else begin
      chk("mem_idle", 32'({mem_en, mem_we}), 32'h0);
      chk("mem_wdata_idle", mem_wdata, 32'h0);
    end
    if (fetch_gnt) n_fgnt++;
    if (fetch_rvalid) n_rvalid++;

    // advance model to the next cycle
    if (exp_rv) void'(exp_q.pop_front());
    if (reset) begin
      exp_q.delete();
      m_boot = 1'b1;
      m_starve = 0;
      m_err = 1'b0;
    end else begin
      if (fg) exp_q.push_back(ff ? NOP_INSTR : img[fi]);
      if (lg && !lf) img[li] = ld_data;
      m_err = (fg && ff) || (lg && lf);
      if (m_boot || !fetch_req || fg) m_starve = 0;
      else if (m_starve < SMAX) m_starve++;
      if (m_boot && ld_done) m_boot = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive(input bit fr, input logic [31:0] fa, input bit lv,
                       input logic [31:0] la, input logic [31:0] ldat, input bit ldn);
    fetch_req = fr; fetch_addr = fa;
    ld_valid = lv; ld_addr = la; ld_data = ldat; ld_done = ldn;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 32'($urandom_range(0, 1023));
    return 32'($urandom_range(0, DEPTH - 1)) << 2;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) img[i] = seed_word(i);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step(); step();
    reset = 1'b0;

    // BOOT holds fetch off regardless of fetch_req
    drive(1, 32'h0, 0, 0, 0, 0);
    step(); step(); step();

    // image load; ld_done coincides with the second write
    drive(1, 32'h0, 1, 32'h0, 32'h0050_0093, 0); step();
    drive(1, 32'h0, 1, 32'h4, 32'h00A0_0113, 1); step();

    // RUN: fetch 0 and 4, then drain
    drive(1, 32'h0, 0, 0, 0, 0); step();
    drive(1, 32'h4, 0, 0, 0, 1); step();
    drive(0, 32'h0, 0, 0, 0, 0); step();
    chk("boot_words_seen", 32'(n_rvalid), 32'd2);

    // starvation: both requesting for 15 cycles -> 4 loads, 1 fetch, repeated
    n_fgnt = 0;
    for (int i = 0; i < 15; i++) begin
      drive(1, 32'h8, 1, 32'(8 + i) << 2, $urandom, 0);
      step();
    end
    chk("starve_fetch_grants", 32'(n_fgnt), 32'd3);
    drive(0, 0, 0, 0, 0, 0); step();

    // streaming fetch: seven back-to-back words
    n_rvalid = 0;
    for (int i = 0; i < 7; i++) begin
      drive(1, 32'(i * 4), 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0); step();
    chk("stream_rvalid_count", 32'(n_rvalid), 32'd7);

    // misaligned and out-of-range fetches
    drive(1, 32'h2, 0, 0, 0, 0); step();
    drive(1, 32'h100, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step(); step();

    // random mixed traffic (ld_done pulses must be ignored in RUN)
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 1) == 1,
            rand_addr(), $urandom, $urandom_range(0, 15) == 0);
      step();
    end

    // reset right after a fetch grant, with the starve counter non-zero before
    drive(1, 32'h10, 1, 32'h20, 32'h1234_5678, 0); step(); step();
    drive(1, 32'h10, 0, 0, 0, 0); step();
    reset = 1'b1;
    drive(1, 32'h10, 1, 32'h20, 32'h1234_5678, 0); step();
    reset = 1'b0;
    drive(1, 32'h10, 0, 0, 0, 0); step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
